// File: rtl/uart_rx_fifo.sv
// Receive-side frame buffer behind the UART receiver: masks each frame to the
// active format, queues it in a circular FIFO and presents it show-ahead to the host.
module uart_rx_fifo #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic          SCLK,
  input  logic          SCLR,
  input  logic [2:0]    UMODE,
  input  logic          RX_STB,
  input  logic [8:0]    RX_DATA,
  input  logic          RX_ERR,
  output logic          DOUT_VALID,
  input  logic          DOUT_READY,
  output logic [7:0]    DOUT,
  output logic          DOUT_PAR,
  output logic          DOUT_ERR,
  input  logic          FLUSH,
  input  logic          STAT_CLR,
  output logic [AW:0]   COUNT,
  output logic          EMPTY,
  output logic          FULL,
  output logic          ALMOST_FULL,
  output logic          OVERRUN,
  output logic [7:0]    ERR_CNT
);

  typedef struct packed {
    logic       err;
    logic       par;
    logic [7:0] data;
  } entry_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);

  // NOTE: the storage array has no reset; only pointers and COUNT define which
  // entries are live, so clearing the RAM would add muxes for no behaviour.
  entry_t        mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          overrun_q;
  logic [7:0]    err_cnt_q;

  logic [7:0]    width_mask;
  entry_t        wr_entry;
  entry_t        head;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;
  logic          drop;
  logic          err_evt;

  // NOTE: every always_comb output gets a default before the case, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    width_mask = 8'hFF;
    case (UMODE[2:1])
      2'b00:   width_mask = 8'h1F;
      2'b01:   width_mask = 8'h3F;
      2'b10:   width_mask = 8'h7F;
      default: width_mask = 8'hFF;
    endcase
  end

  // Masking is frozen at write time, so later UMODE changes never alter stored frames.
  assign wr_entry = '{err: RX_ERR, par: RX_DATA[8] & UMODE[0], data: RX_DATA[7:0] & width_mask};

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);

  // FLUSH discards everything in flight, including a same-cycle frame or pop.
  assign do_pop  = ~empty & DOUT_READY & ~FLUSH;
  assign do_push = RX_STB & ~FLUSH & (~full | do_pop);
  assign drop    = RX_STB & ~FLUSH & full & ~do_pop;
  assign err_evt = do_push & RX_ERR;

  // When full with a pop, wr_ptr == rd_ptr: the head is read out before the
  // edge that overwrites its slot, so the simultaneous write is safe.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge SCLK) begin
    if (do_push && !SCLR) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge SCLK) begin
    if (SCLR || FLUSH) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A new event in the same cycle as STAT_CLR wins over the clear.
  always_ff @(posedge SCLK) begin
    if (SCLR) begin
      overrun_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (drop)          overrun_q <= 1'b1;
      else if (STAT_CLR) overrun_q <= 1'b0;

      if (err_evt) begin
        if (STAT_CLR)                err_cnt_q <= 8'd1;
        else if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end else if (STAT_CLR) begin
        err_cnt_q <= '0;
      end
    end
  end

  assign head        = mem[rd_ptr];
  assign DOUT_VALID  = ~empty;
  assign DOUT        = empty ? 8'h00 : head.data;
  assign DOUT_PAR    = empty ? 1'b0  : head.par;
  assign DOUT_ERR    = empty ? 1'b0  : head.err;

  assign COUNT       = count_q;
  assign EMPTY       = empty;
  assign FULL        = full;
  assign ALMOST_FULL = (count_q >= AF_C);
  assign OVERRUN     = overrun_q;
  assign ERR_CNT     = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected entries, a
// negedge monitor compares each popped head against the queue.
module tb_uart_rx_fifo;

  logic       SCLK = 1'b0;
  logic       SCLR = 1'b1;
  logic [2:0] UMODE = 3'b111;
  logic       RX_STB = 1'b0;
  logic [8:0] RX_DATA = '0;
  logic       RX_ERR = 1'b0;
  logic       DOUT_VALID;
  logic       DOUT_READY = 1'b0;
  logic [7:0] DOUT;
  logic       DOUT_PAR;
  logic       DOUT_ERR;
  logic       FLUSH = 1'b0;
  logic       STAT_CLR = 1'b0;
  logic [4:0] COUNT;
  logic       EMPTY;
  logic       FULL;
  logic       ALMOST_FULL;
  logic       OVERRUN;
  logic [7:0] ERR_CNT;

  int tests = 0;
  int fails = 0;
  logic [9:0] sb_q[$];   // {err, par, data}

  uart_rx_fifo #(.DEPTH(16), .AW(4), .AF_LEVEL(12)) dut (
    .SCLK(SCLK), .SCLR(SCLR), .UMODE(UMODE), .RX_STB(RX_STB), .RX_DATA(RX_DATA),
    .RX_ERR(RX_ERR), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY), .DOUT(DOUT),
    .DOUT_PAR(DOUT_PAR), .DOUT_ERR(DOUT_ERR), .FLUSH(FLUSH), .STAT_CLR(STAT_CLR),
    .COUNT(COUNT), .EMPTY(EMPTY), .FULL(FULL), .ALMOST_FULL(ALMOST_FULL),
    .OVERRUN(OVERRUN), .ERR_CNT(ERR_CNT)
  );

  always #5 SCLK = ~SCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens at the next edge whenever valid & ready hold now.
  always @(negedge SCLK) begin
    if (!SCLR && DOUT_VALID && DOUT_READY && !FLUSH) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        check("head_entry", {22'd0, DOUT_ERR, DOUT_PAR, DOUT}, {22'd0, sb_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge SCLK);
    #1;
  endtask

  // One frame strobe; exp is the hand-computed stored entry, queued if accepted.
  task automatic send(input logic [2:0] mode, input logic [8:0] data, input logic err,
                      input logic [9:0] exp, input logic accept, input logic rdy);
    UMODE = mode; RX_DATA = data; RX_ERR = err; RX_STB = 1'b1; DOUT_READY = rdy;
    if (accept) sb_q.push_back(exp);
    tick();
    RX_STB = 1'b0; RX_ERR = 1'b0; DOUT_READY = 1'b0;
  endtask

  task automatic pop_n(input int n);
    DOUT_READY = 1'b1;
    repeat (n) tick();
    DOUT_READY = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, 32'(COUNT), 32'd0);
    check({tag, "_empty"}, 32'(EMPTY), 32'd1);
    check({tag, "_full"}, 32'(FULL), 32'd0);
    check({tag, "_af"}, 32'(ALMOST_FULL), 32'd0);
    check({tag, "_valid"}, 32'(DOUT_VALID), 32'd0);
    check({tag, "_dout"}, {22'd0, DOUT_ERR, DOUT_PAR, DOUT}, 32'd0);
    check({tag, "_overrun"}, 32'(OVERRUN), 32'd0);
    check({tag, "_errcnt"}, 32'(ERR_CNT), 32'd0);
  endtask

  initial begin
    repeat (2) tick();
    SCLR = 1'b0;
    check_reset_state("rst");

    // Single frame, 8-bit with parity
    send(3'b111, 9'h1A5, 1'b0, 10'h1A5, 1'b1, 1'b0);
    check("single_valid", 32'(DOUT_VALID), 32'd1);
    check("single_dout", 32'(DOUT), 32'hA5);
    check("single_par", 32'(DOUT_PAR), 32'd1);
    check("single_count", 32'(COUNT), 32'd1);
    pop_n(1);
    check("single_empty", 32'(EMPTY), 32'd1);

    // Width / parity masking
    send(3'b000, 9'h1FF, 1'b0, 10'h01F, 1'b1, 1'b0);
    send(3'b101, 9'h1FF, 1'b0, 10'h17F, 1'b1, 1'b0);
    send(3'b011, 9'h1FF, 1'b0, 10'h13F, 1'b1, 1'b0);
    check("mask_5bit_dout", 32'(DOUT), 32'h1F);
    check("mask_5bit_par", 32'(DOUT_PAR), 32'd0);
    pop_n(3);

    // Fill to full, drop one, drain
    for (int i = 0; i < 16; i++) begin
      send(3'b110, 9'(i), 1'b0, 10'(i), 1'b1, 1'b0);
      if (i == 10) check("af_below", 32'(ALMOST_FULL), 32'd0);
      if (i == 11) check("af_at12", 32'(ALMOST_FULL), 32'd1);
      if (i == 14) check("full_at15", 32'(FULL), 32'd0);
    end
    check("full_at16", 32'(FULL), 32'd1);
    check("count_16", 32'(COUNT), 32'd16);
    check("overrun_before", 32'(OVERRUN), 32'd0);
    send(3'b110, 9'h0AA, 1'b0, 10'h0AA, 1'b0, 1'b0);
    check("overrun_set", 32'(OVERRUN), 32'd1);
    check("count_after_drop", 32'(COUNT), 32'd16);
    pop_n(16);
    check("drain_empty", 32'(EMPTY), 32'd1);

    // Full with simultaneous push and pop
    STAT_CLR = 1'b1; tick(); STAT_CLR = 1'b0;
    check("statclr_overrun", 32'(OVERRUN), 32'd0);
    for (int i = 0; i < 16; i++) send(3'b110, 9'(8'h20 + i), 1'b0, 10'(8'h20 + i), 1'b1, 1'b0);
    send(3'b110, 9'h055, 1'b0, 10'h055, 1'b1, 1'b1);
    check("pushpop_overrun", 32'(OVERRUN), 32'd0);
    check("pushpop_count", 32'(COUNT), 32'd16);
    pop_n(16);
    check("pushpop_empty", 32'(EMPTY), 32'd1);

    // Error statistics
    for (int i = 1; i <= 3; i++) send(3'b110, 9'(i), 1'b1, 10'h200 | 10'(i), 1'b1, 1'b0);
    check("errcnt_3", 32'(ERR_CNT), 32'd3);
    check("head_err", 32'(DOUT_ERR), 32'd1);
    STAT_CLR = 1'b1;
    send(3'b110, 9'h004, 1'b1, 10'h204, 1'b1, 1'b0);
    STAT_CLR = 1'b0;
    check("errcnt_clr_wins", 32'(ERR_CNT), 32'd1);
    pop_n(4);
    for (int i = 0; i < 300; i++) begin
      send(3'b110, 9'(i[7:0]), 1'b1, 10'h200 | 10'(i[7:0]), 1'b1, (i > 0));
      if (i == 99) check("errcnt_101", 32'(ERR_CNT), 32'd101);
    end
    check("errcnt_sat", 32'(ERR_CNT), 32'd255);
    pop_n(1);

    // FLUSH with a same-cycle strobe
    for (int i = 0; i < 5; i++) send(3'b110, 9'(i), 1'b0, 10'(i), 1'b1, 1'b0);
    check("pre_flush_count", 32'(COUNT), 32'd5);
    sb_q.delete();
    FLUSH = 1'b1;
    send(3'b110, 9'h0EE, 1'b1, 10'h2EE, 1'b0, 1'b0);
    FLUSH = 1'b0;
    check("flush_count", 32'(COUNT), 32'd0);
    check("flush_empty", 32'(EMPTY), 32'd1);
    check("flush_overrun", 32'(OVERRUN), 32'd0);
    check("flush_errcnt", 32'(ERR_CNT), 32'd255);

    // Reset mid-operation with OVERRUN set
    for (int i = 0; i < 16; i++) send(3'b110, 9'(i), 1'b0, 10'(i), 1'b1, 1'b0);
    send(3'b110, 9'h0BB, 1'b0, 10'h0BB, 1'b0, 1'b0);
    pop_n(11);
    check("pre_rst_count", 32'(COUNT), 32'd5);
    check("pre_rst_overrun", 32'(OVERRUN), 32'd1);
    sb_q.delete();
    SCLR = 1'b1;
    send(3'b110, 9'h0CC, 1'b1, 10'h2CC, 1'b0, 1'b0);
    SCLR = 1'b0;
    check_reset_state("midrst");

    // Pointer wrap: 40 push/pop pairs
    for (int i = 0; i < 40; i++) begin
      send(3'b110, 9'(i), 1'b0, 10'(i), 1'b1, 1'b0);
      pop_n(1);
    end
    check("wrap_empty", 32'(EMPTY), 32'd1);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
